// File: rtl/ifetch_arbiter.sv
// Instruction-fetch responder: round-robin arbitration of two I-cache read
// requests onto the single RAM port, answered with the iwait/iload handshake.
module ifetch_arbiter #(
    parameter int NCORES = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [NCORES-1:0]          iREN,
    input  logic [NCORES*ADDR_W-1:0]   iaddr,
    output logic [NCORES-1:0]          iwait,
    output logic [NCORES*DATA_W-1:0]   iload,
    input  logic                       dbusy,
    output logic                       ibusy,
    output logic                       ramREN,
    output logic [ADDR_W-1:0]          ramaddr,
    input  logic [DATA_W-1:0]          ramload,
    input  logic [1:0]                 ramstate
);

    typedef enum logic {IDLE, FETCH} state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              pick;
    logic [ADDR_W-1:0] pick_addr;
    logic [ADDR_W-1:0] gnt_addr;
    logic              gnt_valid;
    logic              hit;

    always_comb begin
        // The core after the last-served one gets priority; a lone requester always wins.
        pick      = iREN[~last_q] ? ~last_q : last_q;
        pick_addr = pick ? iaddr[2*ADDR_W-1:ADDR_W] : iaddr[ADDR_W-1:0];
        gnt_addr  = grant_q ? iaddr[2*ADDR_W-1:ADDR_W] : iaddr[ADDR_W-1:0];
        gnt_valid = iREN[grant_q] && (gnt_addr == addr_q);
        hit       = (state_q == FETCH) && gnt_valid && (ramstate == RAM_ACCESS);

        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        addr_d  = addr_q;

        case (state_q)
            IDLE: begin
                if (!dbusy && (iREN != '0)) begin
                    grant_d = pick;
                    addr_d  = pick_addr;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (!gnt_valid) begin
                    // Flush or PC redirect: drop silently, pointer untouched.
                    state_d = IDLE;
                end else if (hit) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        iwait   = '1;
        iload   = '0;
        ramREN  = (state_q == FETCH);
        ibusy   = (state_q == FETCH);
        ramaddr = (state_q == FETCH) ? addr_q : '0;
        if (hit) begin
            iwait[grant_q] = 1'b0;
            if (grant_q)
                iload[2*DATA_W-1:DATA_W] = ramload;
            else
                iload[DATA_W-1:0] = ramload;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
        end
    end

endmodule

// File: tb/tb_ifetch_arbiter.sv
// Bench for ifetch_arbiter: directed vector table, hand sequences for
// alternation and mid-fetch reset, then random traffic against a transaction model.
module tb_ifetch_arbiter;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [1:0]  iREN = '0;
    logic [63:0] iaddr = '0;
    logic [1:0]  iwait;
    logic [63:0] iload;
    logic        dbusy = 1'b0;
    logic        ibusy;
    logic        ramREN;
    logic [31:0] ramaddr;
    logic [31:0] ramload = '0;
    logic [1:0]  ramstate = '0;

    int checks = 0;
    int errors = 0;

    ifetch_arbiter #(.NCORES(2), .ADDR_W(32), .DATA_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait),
        .iload(iload), .dbusy(dbusy), .ibusy(ibusy), .ramREN(ramREN),
        .ramaddr(ramaddr), .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  ren;
        logic [31:0] a0, a1;
        logic        db;
        logic [1:0]  rs;
        logic [31:0] rl;
        logic [1:0]  ew;
        logic        eren;
        logic [31:0] eaddr;
        logic [31:0] el0, el1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [1:0] ren, logic [31:0] a0, logic [31:0] a1, logic db,
                                logic [1:0] rs, logic [31:0] rl, logic [1:0] ew, logic eren,
                                logic [31:0] eaddr, logic [31:0] el0, logic [31:0] el1);
        vec_t v;
        v.ren = ren; v.a0 = a0; v.a1 = a1; v.db = db; v.rs = rs; v.rl = rl;
        v.ew = ew; v.eren = eren; v.eaddr = eaddr; v.el0 = el0; v.el1 = el1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] ren, input logic [31:0] a0, input logic [31:0] a1,
                         input logic db, input logic [1:0] rs, input logic [31:0] rl);
        iREN = ren; iaddr = {a1, a0}; dbusy = db; ramstate = rs; ramload = rl;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        drive(2'b00, 0, 0, 1'b0, 2'd0, 0);
        nRST = 1'b0;
        step();
        step();
        chk("rst_iwait", iwait, 2'b11);
        chk("rst_iload", iload, 0);
        chk("rst_ramren", ramREN, 0);
        chk("rst_ramaddr", ramaddr, 0);
        chk("rst_ibusy", ibusy, 0);
        nRST = 1'b1;
    endtask

    // Random-phase transaction model
    int          owner;
    int          last;
    logic [31:0] oaddr;

    initial begin
        int          resp_n;
        int          fetch_cyc;
        int          order[$];
        logic [31:0] ra[2];
        logic [1:0]  ren, ew;
        logic        db, er, h;
        logic [1:0]  rs;
        logic [31:0] rl, ea;
        logic [63:0] el;
        int          pk;

        // ---------------- directed table ----------------
        tbl.push_back(mk(2'b01, 32'h40, 0, 0, 2'd0, 0,            2'b11, 0, 0,      0, 0));
        tbl.push_back(mk(2'b01, 32'h40, 0, 0, 2'd2, 32'hDEADBEEF, 2'b10, 1, 32'h40, 32'hDEADBEEF, 0));
        tbl.push_back(mk(2'b00, 0, 0, 0, 2'd0, 0,                 2'b11, 0, 0,      0, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(2'b10, 0, 32'h200, 1, 2'd2, 32'h5555, 2'b11, 0, 0, 0, 0));
        tbl.push_back(mk(2'b10, 0, 32'h200, 0, 2'd2, 32'h5555,     2'b11, 0, 0,       0, 0));
        tbl.push_back(mk(2'b10, 0, 32'h200, 0, 2'd2, 32'h11112222, 2'b01, 1, 32'h200, 0, 32'h11112222));
        tbl.push_back(mk(2'b00, 0, 0, 0, 2'd0, 0,                  2'b11, 0, 0,       0, 0));
        tbl.push_back(mk(2'b01, 32'h80, 0, 0, 2'd0, 0,             2'b11, 0, 0,       0, 0));
        tbl.push_back(mk(2'b01, 32'h84, 0, 0, 2'd1, 0,             2'b11, 1, 32'h80,  0, 0));
        tbl.push_back(mk(2'b01, 32'h84, 0, 0, 2'd0, 0,             2'b11, 0, 0,       0, 0));
        tbl.push_back(mk(2'b01, 32'h84, 0, 0, 2'd2, 32'h84848484,  2'b10, 1, 32'h84,  32'h84848484, 0));
        tbl.push_back(mk(2'b00, 0, 0, 0, 2'd0, 0,                  2'b11, 0, 0,       0, 0));
        tbl.push_back(mk(2'b01, 32'h300, 0, 0, 2'd0, 0,            2'b11, 0, 0,       0, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(2'b01, 32'h300, 0, 0, 2'd3, 32'hBAD, 2'b11, 1, 32'h300, 0, 0));
        tbl.push_back(mk(2'b01, 32'h300, 0, 0, 2'd2, 32'hCAFEF00D, 2'b10, 1, 32'h300, 32'hCAFEF00D, 0));
        tbl.push_back(mk(2'b00, 0, 0, 0, 2'd0, 0,                  2'b11, 0, 0,       0, 0));

        step();
        do_reset();
        foreach (tbl[i]) begin
            drive(tbl[i].ren, tbl[i].a0, tbl[i].a1, tbl[i].db, tbl[i].rs, tbl[i].rl);
            #2;
            chk($sformatf("v%0d_iwait", i), iwait, tbl[i].ew);
            chk($sformatf("v%0d_ramren", i), ramREN, tbl[i].eren);
            chk($sformatf("v%0d_ibusy", i), ibusy, tbl[i].eren);
            if (tbl[i].eren) chk($sformatf("v%0d_ramaddr", i), ramaddr, tbl[i].eaddr);
            chk($sformatf("v%0d_iload", i), iload, {tbl[i].el1, tbl[i].el0});
            step();
        end

        // ---------------- strict alternation, BUSY x2 then ACCESS ----------------
        do_reset();
        fetch_cyc = 0;
        resp_n = 0;
        for (int cyc = 0; cyc < 60 && resp_n < 4; cyc++) begin
            if (ibusy) fetch_cyc++; else fetch_cyc = 0;
            rl = 32'hA000_0000 + cyc;
            drive(2'b11, 32'h100, 32'h200, 0, (fetch_cyc == 3) ? 2'd2 : 2'd1, rl);
            #2;
            chk("alt_ibusy_ramren", ibusy, ramREN);
            if (iwait != 2'b11) begin
                pk = iwait[0] ? 1 : 0;
                chk("alt_when", cyc, 4 * resp_n + 3);
                chk("alt_addr", ramaddr, pk ? 32'h200 : 32'h100);
                chk("alt_data", iload, pk ? {rl, 32'h0} : {32'h0, rl});
                order.push_back(pk);
                resp_n++;
            end
            step();
        end
        chk("alt_count", order.size(), 4);
        foreach (order[i]) chk("alt_order", order[i], i % 2);

        // ---------------- reset in the middle of a fetch ----------------
        do_reset();
        drive(2'b11, 32'h500, 32'h600, 0, 2'd1, 32'h77);
        step();
        drive(2'b11, 32'h500, 32'h600, 0, 2'd2, 32'h77);
        #2;
        chk("mr_first", iwait, 2'b10);
        step();
        drive(2'b11, 32'h500, 32'h600, 0, 2'd1, 32'h77);
        step();
        chk("mr_core1_addr", ramaddr, 32'h600);
        nRST = 1'b0;
        #1;
        chk("mr_iwait", iwait, 2'b11);
        chk("mr_ramren", ramREN, 0);
        chk("mr_ibusy", ibusy, 0);
        chk("mr_iload", iload, 0);
        step();
        nRST = 1'b1;
        step();
        drive(2'b11, 32'h500, 32'h600, 0, 2'd2, 32'h99);
        #2;
        chk("mr_regrant_addr", ramaddr, 32'h500);
        chk("mr_regrant_iwait", iwait, 2'b10);
        step();

        // ---------------- random traffic vs transaction model ----------------
        do_reset();
        owner = -1;
        last = 1;
        oaddr = '0;
        ra[0] = 32'h1000;
        ra[1] = 32'h2000;
        ren = 2'b00;
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int n = 0; n < 2; n++) begin
                if ($urandom_range(3) == 0) ren[n] = ~ren[n];
                if ($urandom_range(7) == 0) ra[n] = (n ? 32'h2000 : 32'h1000) + 4 * $urandom_range(1);
            end
            db = ($urandom_range(3) == 0);
            rs = 2'($urandom_range(3));
            rl = $urandom;
            drive(ren, ra[0], ra[1], db, rs, rl);
            #2;
            ew = 2'b11; el = '0; er = 1'b0; ea = '0; h = 1'b0;
            if (owner >= 0) begin
                er = 1'b1;
                ea = oaddr;
                h = ren[owner] && (ra[owner] == oaddr) && (rs == 2'd2);
                if (h) begin
                    ew[owner] = 1'b0;
                    el[owner*32 +: 32] = rl;
                end
            end
            chk("rnd_iwait", iwait, ew);
            chk("rnd_iload", iload, el);
            chk("rnd_ramren", ramREN, er);
            chk("rnd_ibusy", ibusy, er);
            chk("rnd_ramaddr", ramaddr, ea);
            if (owner < 0) begin
                if (!db && ren != 2'b00) begin
                    owner = ren[1 - last] ? 1 - last : last;
                    oaddr = ra[owner];
                end
            end else if (h) begin
                last = owner;
                owner = -1;
            end else if (!ren[owner] || ra[owner] != oaddr) begin
                owner = -1;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
